hazard_ctrl: RTL and testbench

- Sequences the pipeline registers of the 5-stage RV32I core: drives PC write-enable, IF/ID write-enable and flush, ID/EX write-enable and bubble, EX/MEM hold, and MEM/WB bubble.
- Resolves three hazard classes: load-use (multi-cycle stall), taken branch/jump redirect (flush), and data-memory wait (full freeze).
- Holds an FSM, a stall counter, a memory-timeout watchdog and saturating performance counters.

---
 rtl/hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing for the 5-stage RV32I core.
//
// Drives the write-enable / flush controls of the pipeline registers and
// resolves three hazard classes:
//   - load-use      : ID reads a register a load in EX is still producing;
//                     holds PC and IF/ID and injects LOAD_STALL_CYCLES bubbles.
//   - redirect      : branch/jump resolved taken in EX; squashes IF/ID, ID/EX.
//   - data-mem wait : MEM access not complete; freezes the whole pipe.
// Priority within a cycle: mem_stall > branch_taken > load_use.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ID_rs1/rs2, ID_uses_* source registers of the ID instruction
//   EX_MemRead, EX_rd     load in EX and its destination
//   branch_taken          taken redirect resolved in EX this cycle
//   mem_req, mem_ready    MEM-stage data access handshake
//   PC_Write .. MEM_WB_Flush  pipeline-register controls (combinational)
//   stall_state           0 RUN, 1 LOAD_STALL, 2 MEM_WAIT
//   mem_timeout           sticky watchdog flag
//   load_stall_cnt, mem_wait_cnt, flush_cnt  saturating event counters

module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255,
  parameter int unsigned CNT_WIDTH         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ID_rs1,
  input  logic [4:0]           ID_rs2,
  input  logic                 ID_uses_rs1,
  input  logic                 ID_uses_rs2,
  input  logic                 EX_MemRead,
  input  logic [4:0]           EX_rd,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 Instr_Flush,
  output logic                 ID_EX_Write,
  output logic                 ID_EX_Flush,
  output logic                 EX_MEM_Write,
  output logic                 MEM_WB_Flush,
  output logic [1:0]           stall_state,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] load_stall_cnt,
  output logic [CNT_WIDTH-1:0] mem_wait_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  // +2 keeps the width >= 1 even for a zero timeout.
  localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WD_W-1:0]      WD_MAX  = WD_W'(MEM_TIMEOUT);
  localparam logic [WD_W-1:0]      WD_ONE  = WD_W'(1);
  localparam logic [1:0]           SC_LOAD = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  state_e               ret_q, ret_d;      // state to resume after MEM_WAIT
  state_e               eff_state;
  logic [1:0]           sc_q, sc_d;        // remaining load-use bubbles
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] ls_cnt_q, ls_cnt_d;
  logic [CNT_WIDTH-1:0] mw_cnt_q, mw_cnt_d;
  logic [CNT_WIDTH-1:0] fl_cnt_q, fl_cnt_d;

  logic load_use, mem_stall;
  logic bubble, frozen, redirect;

  assign load_use = EX_MemRead && (EX_rd != 5'd0) &&
                    ((ID_uses_rs1 && (ID_rs1 == EX_rd)) ||
                     (ID_uses_rs2 && (ID_rs2 == EX_rd)));
  assign mem_stall = mem_req && !mem_ready;

  // Once the memory stops stalling, MEM_WAIT behaves exactly like the state
  // it interrupted, so the ready cycle is evaluated against ret_q.
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    Instr_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Flush = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    sc_d         = sc_q;
    bubble       = 1'b0;
    frozen       = 1'b0;
    redirect     = 1'b0;

    if (mem_stall) begin
      // Full freeze: only MEM/WB moves, and it takes a bubble.
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
      frozen       = 1'b1;
      state_d      = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) ret_d = state_q;
    end else if (branch_taken) begin
      // Redirect wins over any pending load-use stall.
      Instr_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      redirect    = 1'b1;
      sc_d        = 2'd0;
      state_d     = ST_RUN;
    end else if (eff_state == ST_LOAD_STALL) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      bubble      = 1'b1;
      if (sc_q <= 2'd1) begin
        sc_d    = 2'd0;
        state_d = ST_RUN;
      end else begin
        sc_d    = sc_q - 2'd1;
        state_d = ST_LOAD_STALL;
      end
    end else if (load_use) begin
      // First bubble is issued from RUN; extra ones come from LOAD_STALL.
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      bubble      = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        sc_d    = SC_LOAD;
        state_d = ST_LOAD_STALL;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
    end
  end

  // Watchdog counts consecutive freeze cycles and saturates at the limit;
  // the flag stays set until reset even after the access completes.
  always_comb begin
    wd_d          = '0;
    mem_timeout_d = mem_timeout_q;
    if (frozen) begin
      wd_d = (wd_q >= WD_MAX) ? WD_MAX : wd_q + WD_ONE;
      if (wd_d >= WD_MAX) mem_timeout_d = 1'b1;
    end
  end

  always_comb begin
    ls_cnt_d = ls_cnt_q;
    mw_cnt_d = mw_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (bubble   && (ls_cnt_q != '1)) ls_cnt_d = ls_cnt_q + CNT_ONE;
    if (frozen   && (mw_cnt_q != '1)) mw_cnt_d = mw_cnt_q + CNT_ONE;
    if (redirect && (fl_cnt_q != '1)) fl_cnt_d = fl_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      ret_q         <= ST_RUN;
      sc_q          <= 2'd0;
      wd_q          <= '0;
      mem_timeout_q <= 1'b0;
      ls_cnt_q      <= '0;
      mw_cnt_q      <= '0;
      fl_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      sc_q          <= sc_d;
      wd_q          <= wd_d;
      mem_timeout_q <= mem_timeout_d;
      ls_cnt_q      <= ls_cnt_d;
      mw_cnt_q      <= mw_cnt_d;
      fl_cnt_q      <= fl_cnt_d;
    end
  end

  assign stall_state    = state_q;
  assign mem_timeout    = mem_timeout_q;
  assign load_stall_cnt = ls_cnt_q;
  assign mem_wait_cnt   = mw_cnt_q;
  assign flush_cnt      = fl_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. Instance a: LOAD_STALL_CYCLES=2, instance b:
// LOAD_STALL_CYCLES=3; both MEM_TIMEOUT=8, sharing one set of inputs.
// Output vector order: {PC_Write, IF_ID_Write, Instr_Flush, ID_EX_Write,
//                       ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush}.

module tb_hazard_ctrl;
  localparam int CW = 32;
  localparam logic [6:0] O_NORM   = 7'b1101010;
  localparam logic [6:0] O_STALL  = 7'b0001110;
  localparam logic [6:0] O_FLUSH  = 7'b1111110;
  localparam logic [6:0] O_FREEZE = 7'b0000001;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic ID_uses_rs1, ID_uses_rs2, EX_MemRead, branch_taken, mem_req, mem_ready;

  logic a_pc, a_ifid, a_ifl, a_idexw, a_idexf, a_exmemw, a_mwbf, a_mt;
  logic b_pc, b_ifid, b_ifl, b_idexw, b_idexf, b_exmemw, b_mwbf, b_mt;
  logic [1:0] a_st, b_st;
  logic [CW-1:0] a_ls, a_mw, a_fl, b_ls, b_mw, b_fl;
  logic [6:0] a_out, b_out;

  assign a_out = {a_pc, a_ifid, a_ifl, a_idexw, a_idexf, a_exmemw, a_mwbf};
  assign b_out = {b_pc, b_ifid, b_ifl, b_idexw, b_idexf, b_exmemw, b_mwbf};

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(8), .CNT_WIDTH(CW)) u_a (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_Write(a_pc), .IF_ID_Write(a_ifid), .Instr_Flush(a_ifl), .ID_EX_Write(a_idexw),
    .ID_EX_Flush(a_idexf), .EX_MEM_Write(a_exmemw), .MEM_WB_Flush(a_mwbf),
    .stall_state(a_st), .mem_timeout(a_mt),
    .load_stall_cnt(a_ls), .mem_wait_cnt(a_mw), .flush_cnt(a_fl)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8), .CNT_WIDTH(CW)) u_b (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_Write(b_pc), .IF_ID_Write(b_ifid), .Instr_Flush(b_ifl), .ID_EX_Write(b_idexw),
    .ID_EX_Flush(b_idexf), .EX_MEM_Write(b_exmemw), .MEM_WB_Flush(b_mwbf),
    .stall_state(b_st), .mem_timeout(b_mt),
    .load_stall_cnt(b_ls), .mem_wait_cnt(b_mw), .flush_cnt(b_fl)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2, mr;
    logic [4:0] rd;
    logic       br, req, rdy;
    logic [6:0] out;
    logic [1:0] st;
    int         ls, mw, fl;   // counter values visible during this cycle
  } vec_t;

  localparam int NV = 27;
  vec_t tv[NV];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic [4:0] rs1, rs2, input logic u1, u2, mr,
                              input logic [4:0] rd, input logic br, req, rdy,
                              input logic [6:0] out, input logic [1:0] st,
                              input int ls, mw, fl);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
    v.br = br; v.req = req; v.rdy = rdy; v.out = out; v.st = st;
    v.ls = ls; v.mw = mw; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, rs2, input logic u1, u2, mr,
                       input logic [4:0] rd, input logic br, req, rdy);
    @(negedge clk);
    ID_rs1 = rs1; ID_rs2 = rs2; ID_uses_rs1 = u1; ID_uses_rs2 = u2;
    EX_MemRead = mr; EX_rd = rd; branch_taken = br; mem_req = req; mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ID_rs1 = '0; ID_rs2 = '0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
    EX_MemRead = 0; EX_rd = '0; branch_taken = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //             rs1 rs2 u1 u2 mr rd br rq rdy  out       st  ls mw fl
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   0, 0, 0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   0, 0, 0, 0);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   0, 0, 0, 0);
    tv[3]  = mk(0, 5, 0, 1, 1, 5, 0, 0, 0, O_STALL,  0, 0, 0, 0);
    tv[4]  = mk(0, 5, 0, 1, 1, 5, 0, 0, 0, O_STALL,  1, 1, 0, 0);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   0, 2, 0, 0);
    tv[6]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, O_NORM,   0, 2, 0, 0);
    tv[7]  = mk(7, 3, 1, 0, 1, 7, 0, 0, 0, O_STALL,  0, 2, 0, 0);
    tv[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_STALL,  1, 3, 0, 0);
    tv[9]  = mk(7, 7, 0, 0, 1, 7, 0, 0, 0, O_NORM,   0, 4, 0, 0);
    tv[10] = mk(0, 5, 0, 1, 1, 5, 1, 0, 0, O_FLUSH,  0, 4, 0, 0);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   0, 4, 0, 1);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, 0, 4, 0, 1);
    tv[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, 2, 4, 1, 1);
    tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, 2, 4, 2, 1);
    tv[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, 2, 4, 3, 1);
    tv[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM,   2, 4, 4, 1);
    tv[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   0, 4, 4, 1);
    tv[18] = mk(0, 5, 0, 1, 1, 5, 0, 0, 0, O_STALL,  0, 4, 4, 1);
    tv[19] = mk(0, 5, 0, 1, 1, 5, 1, 0, 0, O_FLUSH,  1, 5, 4, 1);
    tv[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   0, 5, 4, 2);
    tv[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_FREEZE, 0, 5, 4, 2);
    tv[22] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, O_FLUSH,  2, 5, 5, 2);
    tv[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   0, 5, 5, 3);
    tv[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE, 0, 5, 5, 3);
    tv[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   2, 5, 6, 3);
    tv[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,   0, 5, 6, 3);

    do_reset();

    // Table: instance a, state carried from row to row.
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].rs1, tv[i].rs2, tv[i].u1, tv[i].u2, tv[i].mr, tv[i].rd,
            tv[i].br, tv[i].req, tv[i].rdy);
      chk($sformatf("v%0d_out", i), 32'(a_out), 32'(tv[i].out));
      chk($sformatf("v%0d_state", i), 32'(a_st), 32'(tv[i].st));
      chk($sformatf("v%0d_ls_cnt", i), a_ls, tv[i].ls);
      chk($sformatf("v%0d_mw_cnt", i), a_mw, tv[i].mw);
      chk($sformatf("v%0d_fl_cnt", i), a_fl, tv[i].fl);
      chk($sformatf("v%0d_timeout", i), 32'(a_mt), 32'(0));
    end

    // Instance b: three bubbles per hazard without interruption.
    do_reset();
    drive(0, 5, 0, 1, 1, 5, 0, 0, 0);
    chk("b3_c0_out", 32'(b_out), 32'(O_STALL)); chk("b3_c0_st", 32'(b_st), 0);
    drive(0, 5, 0, 1, 1, 5, 0, 0, 0);
    chk("b3_c1_out", 32'(b_out), 32'(O_STALL)); chk("b3_c1_st", 32'(b_st), 1);
    drive(0, 5, 0, 1, 1, 5, 0, 0, 0);
    chk("b3_c2_out", 32'(b_out), 32'(O_STALL)); chk("b3_c2_st", 32'(b_st), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("b3_c3_out", 32'(b_out), 32'(O_NORM)); chk("b3_c3_st", 32'(b_st), 0);
    chk("b3_ls_cnt", b_ls, 3);

    // Freeze after the first bubble: counter held, still three bubbles.
    drive(0, 5, 0, 1, 1, 5, 0, 0, 0);
    chk("bf_c0_out", 32'(b_out), 32'(O_STALL)); chk("bf_c0_st", 32'(b_st), 0);
    drive(0, 5, 0, 1, 1, 5, 0, 1, 0);
    chk("bf_c1_out", 32'(b_out), 32'(O_FREEZE)); chk("bf_c1_st", 32'(b_st), 1);
    drive(0, 5, 0, 1, 1, 5, 0, 1, 0);
    chk("bf_c2_out", 32'(b_out), 32'(O_FREEZE)); chk("bf_c2_st", 32'(b_st), 2);
    drive(0, 5, 0, 1, 1, 5, 0, 1, 1);
    chk("bf_c3_out", 32'(b_out), 32'(O_STALL)); chk("bf_c3_st", 32'(b_st), 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bf_c4_out", 32'(b_out), 32'(O_STALL)); chk("bf_c4_st", 32'(b_st), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bf_c5_out", 32'(b_out), 32'(O_NORM)); chk("bf_c5_st", 32'(b_st), 0);
    chk("bf_ls_cnt", b_ls, 6);
    chk("bf_mw_cnt", b_mw, 2);

    // Watchdog: flag visible once 8 freeze cycles have elapsed.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk($sformatf("wd_k%0d_timeout", k), 32'(b_mt), (k >= 9) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("wd_rdy_out", 32'(b_out), 32'(O_NORM));
    chk("wd_rdy_timeout", 32'(b_mt), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_after_st", 32'(b_st), 0);
    chk("wd_after_timeout", 32'(b_mt), 1);
    chk("wd_mw_cnt", b_mw, 10);

    // Reset in the middle of a wait.
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_pre_st", 32'(b_st), 2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_b_st", 32'(b_st), 0);
    chk("rst_b_timeout", 32'(b_mt), 0);
    chk("rst_b_mw_cnt", b_mw, 0);
    chk("rst_a_st", 32'(a_st), 0);
    chk("rst_a_ls_cnt", a_ls, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_req = 1'b0;
    #1;
    chk("rst_idle_out", 32'(b_out), 32'(O_NORM));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
